// File: rtl/mem_responder.sv
// mem_responder: target-side single-port memory for the ce/we access protocol.
// Writes land in storage at the sampling edge. Reads return data one clock later,
// and datao holds that value until the next read. A valid bit per location flags
// reads of never-written locations. Counters record completed accesses, where a
// request held unchanged across several edges counts as one access.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   ce, we     chip enable / write enable (we qualified by ce)
//   addr       access address; addr >= DEPTH is out of range
//   datai      write data
//   datao      registered read data, holds last read value
//   rd_valid   pulse: datao updated by a read at the previous edge
//   rd_uninit  pulse with rd_valid: location had not been written since reset
//   addr_err   pulse: previous-edge request was out of range
//   wr_count   saturating count of completed write accesses
//   rd_count   saturating count of completed read accesses
module mem_responder #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] datai,
  output logic [DATA_W-1:0] datao,
  output logic              rd_valid,
  output logic              rd_uninit,
  output logic              addr_err,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   datao_q, datao_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_uninit_q, rd_uninit_d;
  logic                addr_err_q, addr_err_d;
  logic [15:0]         wr_count_q, wr_count_d;
  logic [15:0]         rd_count_q, rd_count_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                in_range;
  logic                new_access;
  logic                cur_valid;
  logic                mem_we;
  logic [IdxW-1:0]     idx;

  always_comb begin
    state_d     = ce ? (we ? StWr : StRd) : StIdle;
    // DEPTH may equal 2**ADDR_W, so compare one bit wider than the address.
    in_range    = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
    idx         = addr[IdxW-1:0];
    cur_valid   = valid_q[idx];
    // A state change covers both "was idle" and "we flipped".
    new_access  = ce && ((state_d != state_q) || (addr != addr_q));

    datao_d     = datao_q;
    rd_valid_d  = 1'b0;
    rd_uninit_d = 1'b0;
    addr_err_d  = 1'b0;
    wr_count_d  = wr_count_q;
    rd_count_d  = rd_count_q;
    valid_d     = valid_q;
    mem_we      = 1'b0;

    if (ce) begin
      if (!in_range) begin
        addr_err_d = 1'b1;
      end else if (we) begin
        mem_we       = 1'b1;
        valid_d[idx] = 1'b1;
        if (new_access && (wr_count_q != 16'hFFFF)) begin
          wr_count_d = wr_count_q + 16'd1;
        end
      end else begin
        datao_d     = cur_valid ? mem_q[idx] : '0;
        rd_valid_d  = 1'b1;
        rd_uninit_d = ~cur_valid;
        if (new_access && (rd_count_q != 16'hFFFF)) begin
          rd_count_d = rd_count_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      datao_q     <= '0;
      rd_valid_q  <= 1'b0;
      rd_uninit_q <= 1'b0;
      addr_err_q  <= 1'b0;
      wr_count_q  <= '0;
      rd_count_q  <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr;
      datao_q     <= datao_d;
      rd_valid_q  <= rd_valid_d;
      rd_uninit_q <= rd_uninit_d;
      addr_err_q  <= addr_err_d;
      wr_count_q  <= wr_count_d;
      rd_count_q  <= rd_count_d;
      valid_q     <= valid_d;
    end
  end

  // Storage array is intentionally not reset; valid bits mask stale contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx] <= datai;
    end
  end

  assign datao     = datao_q;
  assign rd_valid  = rd_valid_q;
  assign rd_uninit = rd_uninit_q;
  assign addr_err  = addr_err_q;
  assign wr_count  = wr_count_q;
  assign rd_count  = rd_count_q;

endmodule

// File: doc/mem_responder.md
# mem_responder

Synchronous single-port memory responder for the chip-enable/write-enable memory access protocol. It sits on the target side of the bus. It services single-cycle writes and one-cycle-latency reads, and keeps datao stable while ce is held. It tracks which locations have been written, flags reads of unwritten or out-of-range locations, and counts completed write and read accesses for status readout.

## Interface
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- DEPTH, 256, implemented locations; legal range 1..2**ADDR_W; addresses >= DEPTH are out of range.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset. Asserting (0) clears state immediately; deassertion is sampled on the clk rising edge.
- ce  in  1  chip enable; access request on every rising edge where ce=1.
- we  in  1  1=write, 0=read; qualified by ce.
- addr  in  ADDR_W  access address.
- datai  in  DATA_W  write data.
- datao  out  DATA_W  read data; registered; holds the last read value.
- rd_valid  out  1  one-cycle pulse: datao updated by a read this cycle.
- rd_uninit  out  1  one-cycle pulse with rd_valid: the location read had never been written since reset.
- addr_err  out  1  one-cycle pulse: the previous-edge request had addr >= DEPTH.
- wr_count  out  16  completed write accesses; saturates at 16'hFFFF.
- rd_count  out  16  completed read accesses; saturates at 16'hFFFF.

## Operation
- Storage: DEPTH x DATA_W array. The array itself is not reset.
- Valid bits: one per location (DEPTH flops). All are cleared by reset and set by a write to that location.
- Write: at an edge with ce=1, we=1, addr<DEPTH:
  - mem[addr] <= datai; valid[addr] <= 1.
  - datao is unchanged.
- Read: at an edge with ce=1, we=0, addr<DEPTH:
  - datao <= valid[addr] ? mem[addr] : 0.
  - rd_valid <= 1; rd_uninit <= ~valid[addr].
- Out-of-range: at an edge with ce=1 and addr>=DEPTH:
  - No array or valid-bit update; datao holds.
  - addr_err <= 1; rd_valid <= 0.
- Idle: at an edge with ce=0, nothing changes; all pulses clear to 0.
- Access state machine, tracked per edge on the sampled request:
  - IDLE: ce=0.
  - WR: ce=1, we=1.
  - RD: ce=1, we=0.
  - Transitions follow the sampled ce/we each edge.
- Access counting: an access is counted only when the sampled request starts a new access. That is when:
  - the previous state was IDLE, or
  - we differs from the previous request, or
  - addr differs from the previous request.
- Held requests:
  - A multi-cycle hold of an unchanged write counts once; it rewrites the same data harmlessly.
  - A multi-cycle hold of an unchanged read counts once, and re-reads every edge with rd_valid=1 on each.
- Out-of-range requests are never counted.
- Counters saturate: at 16'hFFFF, further accesses leave the counter at 16'hFFFF.

## Timing
- Reset values: datao=0, rd_valid=0, rd_uninit=0, addr_err=0, wr_count=0, rd_count=0, state=IDLE, all valid bits=0.
- Read latency: 1 clock. For a request sampled at edge E, datao is valid after E, stable through E+1, and held until the next read.
- Write latency: 0 cycles to storage. A read of the same address at E+1 returns the new data.
- Write then read, back-to-back, same address: the read returns the written data with rd_uninit=0.
- Pulse outputs are asserted for exactly the cycle following the sampling edge, and again on each edge while the request is held.
- Counter update visible after the sampling edge of the access's first cycle.
- The we/addr change check compares against the request registered at the previous edge. A change of datai alone during a held write is not a new access, but the array stores the latest datai.
- Reset asserted mid-access: all outputs and valid bits clear asynchronously, and the access is dropped. The first request after release counts as a new access.

## Test plan
- Reset release, then 12 writes:
  - Stimulus: addr 0..11, random datai, ce high 1 cycle each with idle gaps.
  - Required: wr_count=12; rd_count=0; no rd_valid pulses.
- Reads of 0..11, ce held 2 cycles each:
  - datao equals the written data one edge after the first read edge, and is stable on the second.
  - rd_valid is high for 2 cycles per access; rd_count=12; rd_uninit=0.
- Read addr 8'h40 (never written):
  - datao=8'h00, rd_uninit=1, rd_valid=1, rd_count increments by 1.
- Out-of-range with DEPTH=16:
  - Write 8'hAA to addr 8'h20, then read 8'h20.
  - Required: addr_err pulse each time; counters unchanged; datao unchanged; mem[0] unaffected.
- Write 8'h5A to addr 3, then next edge read addr 3:
  - datao=8'h5A after the read edge.
  - Then write 8'hC3 to 3 with ce held 3 cycles: wr_count +1 only.
- Mid-access reset:
  - Assert reset during a held read of a written location.
  - Required: immediate datao=0 and counters=0.
  - Re-read after release: datao=0 with rd_uninit=1.
  - Counter saturation check: force 65540 distinct accesses; wr_count ends at 16'hFFFF.
